// File: rtl/debounce_edge_detector_pkg.sv
// debounce_edge_detector_pkg: FSM state encodings and parameter legality helper
package debounce_edge_detector_pkg;
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_e;
  function automatic bit params_ok(input int sync_stages, input int stable_cycles);
    return sync_stages >= 2 && stable_cycles >= 2 && stable_cycles <= 255;
  endfunction
endpackage

// File: rtl/sync_chain.sv
// sync_chain: plain D-flop synchroniser, sync reset to 0
// ports: clock, reset (sync, active-high), d (async input), q (last stage)
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  always_ff @(posedge clock)
    if (reset) stage_q <= '0;
    else stage_q <= {stage_q[STAGES-2:0], d};
  assign q = stage_q[STAGES-1];
endmodule

// File: rtl/debounce_edge_detector.sv
// debounce_edge_detector: synchronise and debounce d_in, emit level, rise/fall strobes, edge count
// ports: clock, reset (sync, active-high), d_in, enable, count_clr -> level, rise, fall, edge_count
module debounce_edge_detector
  import debounce_edge_detector_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d_in,
  input  logic             enable,
  input  logic             count_clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_count
);
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  if (!params_ok(SYNC_STAGES, STABLE_CYCLES)) begin : g_bad_params
    $error("debounce_edge_detector: illegal SYNC_STAGES/STABLE_CYCLES");
  end
  logic s;
  logic accept;
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic level_q, rise_q, fall_q;
  logic [CNT_W-1:0] ecnt_q;
  sync_chain #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (d_in),
    .q     (s)
  );
  // final sample of a check that still agrees with the candidate level
  always_comb
    accept = enable && cnt_q == LAST &&
             ((state_q == RISE_CHK && s) || (state_q == FALL_CHK && !s));
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      // clear wins over the old value but a coincident accepted edge still counts
      ecnt_q <= (count_clr ? '0 : ecnt_q) + CNT_W'(accept);
      case (state_q)
        LOW:
          if (s && enable) begin
            state_q <= RISE_CHK;
            cnt_q   <= CW'(1);
          end
        RISE_CHK:
          if (!enable || !s) begin
            state_q <= LOW;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= HIGH;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else cnt_q <= cnt_q + CW'(1);
        HIGH:
          if (!s && enable) begin
            state_q <= FALL_CHK;
            cnt_q   <= CW'(1);
          end
        FALL_CHK:
          if (!enable || s) begin
            state_q <= HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else cnt_q <= cnt_q + CW'(1);
      endcase
    end
  end
  assign level      = level_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign edge_count = ecnt_q;
endmodule

// File: tb/tb_debounce_edge_detector.sv
// tb_debounce_edge_detector: directed self-checking bench for debounce_edge_detector
module tb_debounce_edge_detector;
  logic clock = 1'b0;
  logic reset, d_in, enable, count_clr;
  logic level, rise, fall;
  logic [7:0] edge_count;
  int checks = 0;
  int errors = 0;
  always #10 clock = ~clock;
  debounce_edge_detector dut (
    .clock      (clock),
    .reset      (reset),
    .d_in       (d_in),
    .enable     (enable),
    .count_clr  (count_clr),
    .level      (level),
    .rise       (rise),
    .fall       (fall),
    .edge_count (edge_count)
  );
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  // flip d_in and wait long enough for the change to be accepted
  task automatic toggle();
    d_in = ~d_in;
    repeat (6) step();
  endtask
  task automatic test_reset();
    reset = 1'b1; d_in = 1'b1; enable = 1'b1; count_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({level, rise, fall, edge_count} !== 11'd0) begin
        errors++;
        $display("FAIL reset[%0d]: level=%b rise=%b fall=%b count=%0d, want all 0", i, level, rise, fall, edge_count);
      end
    end
    reset = 1'b0; d_in = 1'b0;
    repeat (4) step();
  endtask
  task automatic test_glitch();
    d_in = 1'b1;
    repeat (3) step();
    d_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (level !== 1'b0 || rise !== 1'b0 || edge_count !== 8'd0) begin
        errors++;
        $display("FAIL glitch[%0d]: level=%b rise=%b count=%0d, want 0 0 0", i, level, rise, edge_count);
      end
    end
  endtask
  task automatic test_clean_rise();
    d_in = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      step();
      checks++;
      if (rise !== (i == 5) || level !== (i >= 5) || fall !== 1'b0) begin
        errors++;
        $display("FAIL rise[k+%0d]: rise=%b level=%b fall=%b, want %b %b 0", i, rise, level, fall, i == 5, i >= 5);
      end
    end
    checks++;
    if (edge_count !== 8'd1) begin
      errors++;
      $display("FAIL rise_count: count=%0d, want 1", edge_count);
    end
  endtask
  task automatic test_fall_enable();
    d_in = 1'b0;
    repeat (3) step();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (level !== 1'b1 || fall !== 1'b0) begin
        errors++;
        $display("FAIL fall_abort[%0d]: level=%b fall=%b, want 1 0", i, level, fall);
      end
    end
    enable = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      step();
      checks++;
      if (fall !== (i == 3) || level !== (i < 3) || rise !== 1'b0) begin
        errors++;
        $display("FAIL fall[j+%0d]: fall=%b level=%b rise=%b, want %b %b 0", i, fall, level, rise, i == 3, i < 3);
      end
    end
    checks++;
    if (edge_count !== 8'd2) begin
      errors++;
      $display("FAIL fall_count: count=%0d, want 2", edge_count);
    end
  endtask
  task automatic test_count_edges();
    repeat (253) toggle();
    checks++;
    if (edge_count !== 8'd255 || level !== 1'b1) begin
      errors++;
      $display("FAIL count_255: count=%0d level=%b, want 255 1", edge_count, level);
    end
    toggle();
    checks++;
    if (edge_count !== 8'd0 || level !== 1'b0) begin
      errors++;
      $display("FAIL count_wrap: count=%0d level=%b, want 0 0", edge_count, level);
    end
    repeat (2) toggle();
    d_in = 1'b1;
    repeat (5) step();
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    checks++;
    if (rise !== 1'b1 || edge_count !== 8'd1) begin
      errors++;
      $display("FAIL clr_with_rise: rise=%b count=%0d, want 1 1", rise, edge_count);
    end
    step();
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    checks++;
    if (edge_count !== 8'd0 || level !== 1'b1) begin
      errors++;
      $display("FAIL clr_alone: count=%0d level=%b, want 0 1", edge_count, level);
    end
  endtask
  task automatic test_reset_mid_check();
    toggle();
    d_in = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (level !== 1'b0 || rise !== 1'b0 || edge_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: level=%b rise=%b count=%0d, want 0 0 0", level, rise, edge_count);
    end
    for (int i = 5; i <= 10; i++) begin
      step();
      checks++;
      if (rise !== (i == 10) || level !== (i == 10) || fall !== 1'b0) begin
        errors++;
        $display("FAIL reset_restart[k+%0d]: rise=%b level=%b fall=%b, want %b %b 0", i, rise, level, fall, i == 10, i == 10);
      end
    end
  endtask
  initial begin
    test_reset();
    test_glitch();
    test_clean_rise();
    test_fall_enable();
    test_count_edges();
    test_reset_mid_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
